// File: rtl/pacote_memoria.sv
// Shared types for the data-memory controller: access-size codes, controller
// states and the captured-request payload.
package pacote_memoria;

    localparam int unsigned LARGURA_DADO = 32;

    // Access size as encoded on req_tamanho
    typedef enum logic [1:0] {
        TAM_BYTE   = 2'b00,
        TAM_HALF   = 2'b01,
        TAM_WORD   = 2'b10,
        TAM_ILEGAL = 2'b11
    } tamanho_t;

    // Controller states
    typedef enum logic [1:0] {
        OCIOSO   = 2'b00,
        LEITURA  = 2'b01,
        ESCRITA  = 2'b10,
        RESPOSTA = 2'b11
    } estado_t;

    // Request fields still needed after the accept edge
    typedef struct packed {
        logic                    escrita;
        tamanho_t                tamanho;
        logic                    sinal;
        logic [1:0]              pista;
        logic [LARGURA_DADO-1:0] dado;
    } requisicao_t;

endpackage

// File: rtl/alinhador_bytes.sv
// Combinational lane steering for sub-word accesses (little-endian lanes).
// Ports:
//   tamanho            access size
//   sinal              loads: 1 sign-extend, 0 zero-extend
//   pista              byte address bits [1:0]
//   dado_novo          right-aligned store data
//   palavra_lida       word read from memory
//   palavra_mesclada_c palavra_lida with the selected lane replaced by dado_novo
//   dado_extraido_c    selected lane of palavra_lida, right-aligned and extended
module alinhador_bytes
    import pacote_memoria::*;
(
    input  tamanho_t                tamanho,
    input  logic                    sinal,
    input  logic [1:0]              pista,
    input  logic [LARGURA_DADO-1:0] dado_novo,
    input  logic [LARGURA_DADO-1:0] palavra_lida,
    output logic [LARGURA_DADO-1:0] palavra_mesclada_c,
    output logic [LARGURA_DADO-1:0] dado_extraido_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Store merge: only the addressed lane changes
    always_comb begin
        palavra_mesclada_c = palavra_lida;
        case (tamanho)
            TAM_BYTE: palavra_mesclada_c[{pista, 3'b000} +: 8]      = dado_novo[7:0];
            TAM_HALF: palavra_mesclada_c[{pista[1], 4'b0000} +: 16] = dado_novo[15:0];
            TAM_WORD: palavra_mesclada_c = dado_novo;
            default:  palavra_mesclada_c = palavra_lida;
        endcase
    end

    // Load extract and extend
    always_comb begin
        byte_sel        = 8'(palavra_lida >> {pista, 3'b000});
        half_sel        = 16'(palavra_lida >> {pista[1], 4'b0000});
        dado_extraido_c = palavra_lida;
        case (tamanho)
            TAM_BYTE: dado_extraido_c = {{24{sinal & byte_sel[7]}}, byte_sel};
            TAM_HALF: dado_extraido_c = {{16{sinal & half_sel[15]}}, half_sel};
            default:  dado_extraido_c = palavra_lida;
        endcase
    end

endmodule

// File: rtl/controlador_memoria_dados.sv
// CPU-side initiator for the word-addressed data memory. Accepts byte/half/word
// loads and stores over valid/ready; sub-word stores are read-modify-write.
// Optional feature: define LIMITE_MEMORIA_EN to flag word addresses >= PALAVRAS
// as errors; otherwise the address is only truncated to LARGURA_END bits.
// Ports:
//   clock, reset                  rising-edge clock, async active-high reset
//   req_valid/req_ready           request handshake (ready only when idle)
//   req_escrita, req_tamanho      store flag, size code
//   req_sinal                     load sign-extension
//   req_endereco, req_dado        byte address, right-aligned store data
//   resp_valid/resp_ready         response handshake
//   resp_dado, resp_erro          load result (0 for stores/errors), error flag
//   mem_endereco                  word address to memory
//   mem_memWrite                  write strobe
//   mem_dado_Escrito              write word
//   mem_dado_Lido                 combinational read data from memory
module controlador_memoria_dados
    import pacote_memoria::*;
#(
    parameter int unsigned LARGURA_END = 26,
    parameter int unsigned PALAVRAS    = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_escrita,
    input  logic [1:0]              req_tamanho,
    input  logic                    req_sinal,
    input  logic [31:0]             req_endereco,
    input  logic [LARGURA_DADO-1:0] req_dado,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [LARGURA_DADO-1:0] resp_dado,
    output logic                    resp_erro,
    output logic [LARGURA_END-1:0]  mem_endereco,
    output logic                    mem_memWrite,
    output logic [LARGURA_DADO-1:0] mem_dado_Escrito,
    input  logic [LARGURA_DADO-1:0] mem_dado_Lido
);

`ifdef LIMITE_MEMORIA_EN
    localparam bit LIMITE_ATIVO = 1'b1;
`else
    localparam bit LIMITE_ATIVO = 1'b0;
`endif

    estado_t                 estado, estado_prox;
    requisicao_t             req_r, req_prox;
    logic [LARGURA_END-1:0]  mem_endereco_prox;
    logic [LARGURA_DADO-1:0] dado_escrito_prox;
    logic [LARGURA_DADO-1:0] resp_dado_prox;
    logic                    resp_erro_prox;

    tamanho_t                tam_c;
    logic [LARGURA_END-1:0]  palavra_req_c;
    logic                    erro_tam_c;
    logic                    fora_faixa_c;
    logic                    erro_c;
    logic [LARGURA_DADO-1:0] palavra_mesclada_c;
    logic [LARGURA_DADO-1:0] dado_extraido_c;
    logic                    endereco_alto_unused_c;

    // Address bits above the word-address field carry no meaning here
    assign endereco_alto_unused_c = ^req_endereco[31:LARGURA_END+2];

    // Request decode and error classification
    always_comb begin
        tam_c         = tamanho_t'(req_tamanho);
        palavra_req_c = req_endereco[LARGURA_END+1:2];
        erro_tam_c    = (tam_c == TAM_ILEGAL)
                      | ((tam_c == TAM_HALF) & req_endereco[0])
                      | ((tam_c == TAM_WORD) & (req_endereco[1:0] != 2'b00));
        fora_faixa_c  = (32'(palavra_req_c) >= 32'(PALAVRAS));
        erro_c        = erro_tam_c | (LIMITE_ATIVO & fora_faixa_c);
    end

    // Lane steering works on the captured request and the live read data
    alinhador_bytes u_alinhador (
        .tamanho            (req_r.tamanho),
        .sinal              (req_r.sinal),
        .pista              (req_r.pista),
        .dado_novo          (req_r.dado),
        .palavra_lida       (mem_dado_Lido),
        .palavra_mesclada_c (palavra_mesclada_c),
        .dado_extraido_c    (dado_extraido_c)
    );

    // Next-state and datapath
    always_comb begin
        estado_prox       = estado;
        req_prox          = req_r;
        mem_endereco_prox = mem_endereco;
        dado_escrito_prox = mem_dado_Escrito;
        resp_dado_prox    = resp_dado;
        resp_erro_prox    = resp_erro;

        case (estado)
            OCIOSO: begin
                if (req_valid) begin
                    req_prox = '{escrita: req_escrita, tamanho: tam_c, sinal: req_sinal,
                                 pista: req_endereco[1:0], dado: req_dado};
                    resp_dado_prox = '0;
                    resp_erro_prox = 1'b0;
                    if (erro_c) begin
                        // No memory access; mem_endereco keeps its old value
                        resp_erro_prox = 1'b1;
                        estado_prox    = RESPOSTA;
                    end else begin
                        mem_endereco_prox = palavra_req_c;
                        if (req_escrita && (tam_c == TAM_WORD)) begin
                            dado_escrito_prox = req_dado;
                            estado_prox       = ESCRITA;
                        end else begin
                            estado_prox = LEITURA;
                        end
                    end
                end
            end
            LEITURA: begin
                if (req_r.escrita) begin
                    dado_escrito_prox = palavra_mesclada_c;
                    estado_prox       = ESCRITA;
                end else begin
                    resp_dado_prox = dado_extraido_c;
                    estado_prox    = RESPOSTA;
                end
            end
            ESCRITA: begin
                estado_prox = RESPOSTA;
            end
            RESPOSTA: begin
                if (resp_ready) begin
                    estado_prox = OCIOSO;
                end
            end
            default: begin
                estado_prox = OCIOSO;
            end
        endcase
    end

    // State and output registers; handshake/strobe flops track the next state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado           <= OCIOSO;
            req_r            <= '0;
            mem_endereco     <= '0;
            mem_dado_Escrito <= '0;
            resp_dado        <= '0;
            resp_erro        <= 1'b0;
            resp_valid       <= 1'b0;
            mem_memWrite     <= 1'b0;
            req_ready        <= 1'b1;
        end else begin
            estado           <= estado_prox;
            req_r            <= req_prox;
            mem_endereco     <= mem_endereco_prox;
            mem_dado_Escrito <= dado_escrito_prox;
            resp_dado        <= resp_dado_prox;
            resp_erro        <= resp_erro_prox;
            resp_valid       <= (estado_prox == RESPOSTA);
            mem_memWrite     <= (estado_prox == ESCRITA);
            req_ready        <= (estado_prox == OCIOSO);
        end
    end

endmodule
